// File: rtl/des_ui_pkg.sv
// Shared definitions for the DES demo board controllers: state codes, chunk
// count and the helpers that map 16-bit switch chunks and display words.
package des_ui_pkg;

    localparam logic [4:0] ST_IDLE       = 5'b00000;
    localparam logic [4:0] ST_IN_KEY     = 5'b00001;
    localparam logic [4:0] ST_IN_CT      = 5'b00010;
    localparam logic [4:0] ST_READY      = 5'b00011;
    localparam logic [4:0] ST_START_CORE = 5'b00100;
    localparam logic [4:0] ST_WAIT_CORE  = 5'b00101;
    localparam logic [4:0] ST_DONE       = 5'b00110;
    localparam logic [4:0] ST_ERROR      = 5'b11111;

    localparam int CHUNKS = 4;

    // Word 0 is the least significant 16 bits, word 3 the most significant.
    function automatic logic [15:0] word_select(input logic [63:0] w, input logic [1:0] sel);
        logic [15:0] r;
        case (sel)
            2'd0:    r = w[15:0];
            2'd1:    r = w[31:16];
            2'd2:    r = w[47:32];
            default: r = w[63:48];
        endcase
        return r;
    endfunction

    // Chunks arrive most significant first: index 0 fills [63:48].
    function automatic logic [63:0] load_chunk(input logic [63:0] w, input logic [1:0] idx,
                                               input logic [15:0] chunk);
        logic [63:0] r;
        r = w;
        case (idx)
            2'd0:    r[63:48] = chunk;
            2'd1:    r[47:32] = chunk;
            2'd2:    r[31:16] = chunk;
            default: r[15:0]  = chunk;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low button;
// emits a single registered press pulse per 1->0 transition.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            prev   <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            prev   <= sync_2;
            press  <= prev & ~sync_2;
        end
    end

endmodule

// File: rtl/seven_segment.sv
// Hex nibble to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module seven_segment (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/text_decryption.sv
// Decrypt-side board controller: collects key and ciphertext from switches,
// runs an external DES core in decrypt mode and displays any 16-bit word.
module text_decryption
    import des_ui_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_data,
    input  logic [15:0] user_input,
    input  logic        decr_go,
    input  logic [1:0]  select_disp,
    output logic        core_start,
    output logic        core_decrypt,
    output logic [63:0] core_key,
    output logic [63:0] core_din,
    input  logic        core_done,
    input  logic [63:0] core_dout,
    output logic [63:0] msg,
    output logic        busy,
    output logic        error,
    output logic [6:0]  seg7_most,
    output logic [6:0]  seg7_most_2,
    output logic [6:0]  seg7_least_2,
    output logic [6:0]  seg7_least,
    output logic [4:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [4:0]    state;
    logic [2:0]    chunk_cnt;
    logic [TW-1:0] tcnt;
    logic          press;
    logic [63:0]   disp_src;
    logic [15:0]   disp_word;

    btn_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn_n (send_data),
        .press (press)
    );

    assign core_decrypt = 1'b1;
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            core_key   <= '0;
            core_din   <= '0;
            msg        <= '0;
            chunk_cnt  <= '0;
            tcnt       <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_IN_KEY;
                ST_IN_KEY: begin
                    if (press) begin
                        core_key <= load_chunk(core_key, chunk_cnt[1:0], user_input);
                        if (chunk_cnt == 3'(CHUNKS - 1)) begin
                            chunk_cnt <= '0;
                            state     <= ST_IN_CT;
                        end else begin
                            chunk_cnt <= chunk_cnt + 3'd1;
                        end
                    end
                end
                ST_IN_CT: begin
                    if (press) begin
                        core_din <= load_chunk(core_din, chunk_cnt[1:0], user_input);
                        if (chunk_cnt == 3'(CHUNKS - 1)) begin
                            chunk_cnt <= '0;
                            state     <= ST_READY;
                        end else begin
                            chunk_cnt <= chunk_cnt + 3'd1;
                        end
                    end
                end
                ST_READY: begin
                    if (decr_go) begin
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_START_CORE;
                    end
                end
                ST_START_CORE: begin
                    tcnt  <= '0;
                    state <= ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    // A done arriving on the final timeout cycle still counts.
                    if (core_done) begin
                        msg   <= core_dout;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        state <= ST_ERROR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (press) begin
                        chunk_cnt <= '0;
                        state     <= ST_IN_KEY;
                    end
                end
                ST_ERROR: error <= 1'b1;
                default: begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= ST_ERROR;
                end
            endcase
        end
    end

    always_comb begin
        disp_src = '0;
        case (state)
            ST_IN_KEY:                   disp_src = core_key;
            ST_IN_CT, ST_READY:          disp_src = core_din;
            ST_START_CORE, ST_WAIT_CORE,
            ST_DONE, ST_ERROR:           disp_src = msg;
            default:                     disp_src = '0;
        endcase
    end

    assign disp_word = word_select(disp_src, select_disp);

    seven_segment u_seg3 (.nibble(disp_word[15:12]), .seg(seg7_most));
    seven_segment u_seg2 (.nibble(disp_word[11:8]),  .seg(seg7_most_2));
    seven_segment u_seg1 (.nibble(disp_word[7:4]),   .seg(seg7_least_2));
    seven_segment u_seg0 (.nibble(disp_word[3:0]),   .seg(seg7_least));

endmodule

// File: tb/tb_text_decryption.sv
// Self-checking bench for text_decryption: a model DES core, randomized entry
// rounds and a state-transition scoreboard fed by a high-level model.
module tb_text_decryption;
    import des_ui_pkg::*;

    localparam int TIMEOUT  = 255;
    localparam int CORE_LAT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        send_data = 1'b1;
    logic [15:0] user_input = '0;
    logic        decr_go = 1'b0;
    logic [1:0]  select_disp = '0;
    logic        core_start;
    logic        core_decrypt;
    logic [63:0] core_key;
    logic [63:0] core_din;
    logic        core_done = 1'b0;
    logic [63:0] core_dout = '0;
    logic [63:0] msg;
    logic        busy;
    logic        error;
    logic [6:0]  seg7_most;
    logic [6:0]  seg7_most_2;
    logic [6:0]  seg7_least_2;
    logic [6:0]  seg7_least;
    logic [4:0]  dbg_state;

    text_decryption #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .send_data    (send_data),
        .user_input   (user_input),
        .decr_go      (decr_go),
        .select_disp  (select_disp),
        .core_start   (core_start),
        .core_decrypt (core_decrypt),
        .core_key     (core_key),
        .core_din     (core_din),
        .core_done    (core_done),
        .core_dout    (core_dout),
        .msg          (msg),
        .busy         (busy),
        .error        (error),
        .seg7_most    (seg7_most),
        .seg7_most_2  (seg7_most_2),
        .seg7_least_2 (seg7_least_2),
        .seg7_least   (seg7_least),
        .dbg_state    (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: one record per expected state change.
    typedef struct packed {
        logic [4:0]  st;
        logic [63:0] key;
        logic [63:0] din;
        logic [63:0] msg;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] mdl_key = '0;
    logic [63:0] mdl_din = '0;
    logic [63:0] mdl_msg = '0;
    int          exp_start = 0;
    int          n_start = 0;
    int          stray_req = 0;
    logic        core_respond = 1'b1;
    logic        mon_en = 1'b0;
    logic [6:0]  seg_tab[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [4:0] st, input logic b, input logic e);
        exp_t r;
        r.st   = st;
        r.key  = mdl_key;
        r.din  = mdl_din;
        r.msg  = mdl_msg;
        r.busy = b;
        r.err  = e;
        exp_q.push_back(r);
    endtask

    // Stand-in for the DES core; the published test vector decrypts exactly.
    function automatic logic [63:0] core_model_out(input logic [63:0] k, input logic [63:0] d);
        if (k == 64'h133457799BBCDFF1 && d == 64'h85E813540F0AB405)
            return 64'h0123456789ABCDEF;
        return d ^ {k[31:0], k[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    // Model DES core
    initial begin
        int          pend;
        int          ack;
        logic [63:0] pval;
        pend = 0;
        ack  = 0;
        pval = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (stray_req != ack) begin
                ack       = stray_req;
                core_done = 1'b1;
                core_dout = 64'hDEADBEEFCAFEF00D;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_dout = pval;
                end
            end else if (core_start && core_respond) begin
                pend = CORE_LAT;
                pval = core_model_out(core_key, core_din);
            end
        end
    end

    // Monitor
    initial begin
        logic [4:0] last;
        logic       prev_start;
        exp_t       e;
        last       = ST_IDLE;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                n_start++;
                chk("start_decrypt_mode", 64'(core_decrypt), 64'd1);
                chk("start_pulse_width", 64'(prev_start), 64'd0);
            end
            prev_start = core_start;
            if (mon_en && dbg_state !== last) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transition", 64'(dbg_state), 64'(last));
                end else begin
                    e = exp_q.pop_front();
                    chk("tr_state", 64'(dbg_state), 64'(e.st));
                    chk("tr_key", core_key, e.key);
                    chk("tr_din", core_din, e.din);
                    chk("tr_msg", msg, e.msg);
                    chk("tr_busy", 64'(busy), 64'(e.busy));
                    chk("tr_error", 64'(error), 64'(e.err));
                end
                last = dbg_state;
            end
        end
    end

    // Driver tasks
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic press_chunk(input logic [15:0] v, input int hold);
        @(negedge clk);
        user_input = v;
        send_data  = 1'b0;
        repeat (hold) @(negedge clk);
        send_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_disp(input logic [1:0] sel, input logic [15:0] word);
        @(negedge clk);
        select_disp = sel;
        @(negedge clk);
        chk("seg7_most", 64'(seg7_most), 64'(seg_tab[word[15:12]]));
        chk("seg7_most_2", 64'(seg7_most_2), 64'(seg_tab[word[11:8]]));
        chk("seg7_least_2", 64'(seg7_least_2), 64'(seg_tab[word[7:4]]));
        chk("seg7_least", 64'(seg7_least), 64'(seg_tab[word[3:0]]));
    endtask

    task automatic enter_word(input logic [63:0] w, input bit is_key, input int hold0);
        logic [63:0] old;
        logic [4:0]  st;
        logic [4:0]  nxt;
        logic [15:0] ch;
        old = is_key ? mdl_key : mdl_din;
        st  = is_key ? ST_IN_KEY : ST_IN_CT;
        nxt = is_key ? ST_IN_CT : ST_READY;
        for (int i = 0; i < CHUNKS; i++) begin
            ch = w[63-16*i -: 16];
            if (i == CHUNKS - 1) begin
                if (is_key) mdl_key = w;
                else        mdl_din = w;
                push_exp(nxt, 1'b0, 1'b0);
            end
            press_chunk(ch, (i == 0) ? hold0 : int'($urandom_range(1, 8)));
            if (i == 0) begin
                check_disp(2'd3, w[63:48]);
                check_disp(2'd0, old[15:0]);
            end
            if (i == 1) begin
                @(negedge clk);
                decr_go = 1'b1;
                @(negedge clk);
                decr_go = 1'b0;
                repeat (4) @(negedge clk);
                chk("ignored_go", 64'(n_start), 64'(exp_start));
            end
            if (i == 2) chk("count_after_3", 64'(dbg_state), 64'(st));
        end
        wait_drain(20);
    endtask

    // mode 0: core answers, 1: core silent until timeout, 2: stop once in WAIT_CORE
    task automatic run_decrypt(input int mode);
        int cnt;
        push_exp(ST_START_CORE, 1'b1, 1'b0);
        push_exp(ST_WAIT_CORE, 1'b1, 1'b0);
        if (mode == 0) begin
            mdl_msg = core_model_out(mdl_key, mdl_din);
            push_exp(ST_DONE, 1'b0, 1'b0);
        end else if (mode == 1) begin
            push_exp(ST_ERROR, 1'b0, 1'b1);
        end
        exp_start++;
        @(negedge clk);
        decr_go = 1'b1;
        @(negedge clk);
        decr_go = 1'b0;
        chk("start_latency", 64'(core_start), 64'd1);
        @(negedge clk);
        chk("start_width", 64'(core_start), 64'd0);
        if (mode == 1) begin
            cnt = 0;
            while (!error && cnt < TIMEOUT + 50) begin
                cnt++;
                @(negedge clk);
            end
            chk("timeout_cycles", 64'(cnt), 64'(TIMEOUT));
            chk("timeout_msg", msg, 64'd0);
            wait_drain(5);
        end else if (mode == 0) begin
            wait_drain(CORE_LAT + 20);
        end else begin
            wait_drain(10);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        mdl_key = '0;
        mdl_din = '0;
        mdl_msg = '0;
        push_exp(ST_IDLE, 1'b0, 1'b0);
        push_exp(ST_IN_KEY, 1'b0, 1'b0);
        check_disp(2'($urandom_range(0, 3)), 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        wait_drain(10);
    endtask

    task automatic leave_done();
        push_exp(ST_IN_KEY, 1'b0, 1'b0);
        press_chunk(16'($urandom), int'($urandom_range(1, 8)));
        wait_drain(10);
        chk("done_press_key_kept", core_key, mdl_key);
    endtask

    // Main sequence
    initial begin
        logic [63:0] k;
        logic [63:0] c;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        repeat (3) @(negedge clk);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_key", core_key, 64'd0);
        chk("rst_din", core_din, 64'd0);
        chk("rst_msg", msg, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_start", 64'(core_start), 64'd0);
        chk("rst_decrypt", 64'(core_decrypt), 64'd1);
        check_disp(2'd2, 16'h0000);
        mon_en = 1'b1;
        push_exp(ST_IN_KEY, 1'b0, 1'b0);
        rst = 1'b1;
        wait_drain(10);

        // Key entry with a long-held first press, then ignored inputs and timeout.
        enter_word(64'h0123456789ABCDEF, 1'b1, 50);
        chk("key_entered", core_key, 64'h0123456789ABCDEF);
        check_disp(2'd3, 16'h0000);
        c = {$urandom, $urandom};
        enter_word(c, 1'b0, 3);
        check_disp(2'($urandom_range(0, 3)), 16'h0000 | c[15:0]);
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_done_msg", msg, mdl_msg);
        press_chunk(16'hBEEF, 2);
        chk("ready_press_din", core_din, mdl_din);
        for (int s = 0; s < 4; s++) check_disp(2'(s), mdl_din[16*s +: 16]);
        core_respond = 1'b0;
        run_decrypt(1);
        core_respond = 1'b1;
        do_reset();

        // Published DES vector.
        enter_word(64'h133457799BBCDFF1, 1'b1, 4);
        enter_word(64'h85E813540F0AB405, 1'b0, 4);
        run_decrypt(0);
        chk("vector_msg", msg, 64'h0123456789ABCDEF);
        for (int s = 0; s < 4; s++) check_disp(2'(s), mdl_msg[16*s +: 16]);
        leave_done();

        // Random rounds; earlier ciphertext and message stay until overwritten.
        for (int r = 0; r < 3; r++) begin
            k = {$urandom, $urandom};
            c = {$urandom, $urandom};
            enter_word(k, 1'b1, int'($urandom_range(1, 20)));
            enter_word(c, 1'b0, int'($urandom_range(1, 20)));
            run_decrypt(0);
            check_disp(2'(r), mdl_msg[16*r +: 16]);
            leave_done();
        end

        // Reset while the core transaction is outstanding; a late done is ignored.
        enter_word({$urandom, $urandom}, 1'b1, 2);
        enter_word({$urandom, $urandom}, 1'b0, 2);
        core_respond = 1'b0;
        run_decrypt(2);
        do_reset();
        repeat (2) @(negedge clk);
        stray_req++;
        repeat (5) @(negedge clk);
        chk("late_done_state", 64'(dbg_state), 64'(ST_IN_KEY));
        chk("late_done_key", core_key, 64'd0);
        chk("late_done_din", core_din, 64'd0);
        chk("late_done_msg", msg, 64'd0);
        chk("late_done_busy", 64'(busy), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("start_count", 64'(n_start), 64'(exp_start));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_decryption.md
# text_decryption

Board-level controller for the decrypt side of the DES demo. It collects a 64-bit key and a 64-bit ciphertext from 16 switches in four button-press chunks each, then drives an external iterative DES core in decrypt mode over a start/done handshake. It latches the recovered plaintext and shows any 16-bit word of the key, the ciphertext or the plaintext on four seven-segment digits. It is the receiving counterpart of `text_encryption`: entering that block's key and its displayed message must return the original value.

## Interface
- `TIMEOUT`, default 255: maximum cycles to wait for `core_done` after `core_start`.
- `clk` input 1: single system clock; all logic rises on `clk`.
- `rst` input 1: reset, synchronous and active-low.
- `send_data` input 1: chunk-capture button, active-low (pressed = 0), asynchronous to `clk`.
- `user_input` input 16: switch word captured on each press.
- `decr_go` input 1: active-high request to start decryption.
- `select_disp` input 2: selects the displayed word. 0 = [15:0], 1 = [31:16], 2 = [47:32], 3 = [63:48].
- `core_start` output 1: one-cycle pulse to the DES core.
- `core_decrypt` output 1: mode select to the core, held at 1.
- `core_key` output 64: key register.
- `core_din` output 64: ciphertext register.
- `core_done` input 1: one-cycle pulse from the core; `core_dout` is valid in the same cycle.
- `core_dout` input 64: plaintext from the core.
- `msg` output 64: latched plaintext.
- `busy` output 1: high in `START_CORE` and `WAIT_CORE`.
- `error` output 1: high in `ERROR`.
- `seg7_most`, `seg7_most_2`, `seg7_least_2`, `seg7_least` output 7 each: segment drives for nibbles 3, 2, 1 and 0 of the selected word.

## Operation
- **Button path.** `send_data` passes through a 2-flop synchronizer and then a falling-edge detector.
  - One press (a 1→0 transition) gives exactly one `press` pulse, however long the button is held.
  - The press counter is 3 bits wide.
- **Chunk order.** Chunks are captured MSW first.
  - Press 1 loads [63:48], press 2 [47:32], press 3 [31:16], press 4 [15:0].
  - A chunk is loaded on the `press` cycle itself.
- **States and transitions.**
  - `IDLE` → `IN_KEY` on the first cycle after reset.
  - `IN_KEY`: presses load `core_key`. After the 4th press, go to `IN_CT` and clear the counter.
  - `IN_CT`: presses load `core_din`. After the 4th press, go to `READY`.
  - `READY`: wait for `decr_go` = 1, then go to `START_CORE`. Presses in this state are ignored.
  - `START_CORE`: assert `core_start` for one cycle, clear the timeout counter, go to `WAIT_CORE`.
  - `WAIT_CORE`: on `core_done`, load `msg` from `core_dout` and go to `DONE`. If the counter reaches `TIMEOUT` first, go to `ERROR`.
  - `DONE`: hold. A press re-enters `IN_KEY` with the counter cleared; `msg` is retained.
  - `ERROR`: hold until `rst`. `default` goes to `ERROR`.
- **Display source** (word selected by `select_disp`, split into nibbles for the four digits):
  - `IN_KEY` shows `core_key`.
  - `IN_CT` and `READY` show `core_din`.
  - `START_CORE`, `WAIT_CORE`, `DONE` and `ERROR` show `msg`.
  - `IDLE` shows 0.
- **Simultaneous events.**
  - `decr_go` arriving in any state other than `READY` is ignored.
  - `core_done` arriving outside `WAIT_CORE` is ignored.
  - If `core_done` and the timeout occur in the same cycle, `core_done` wins.

## Timing
- **Reset values.** `rst` = 0 sampled on an edge gives:
  - state `IDLE`;
  - `core_key`, `core_din`, `msg` all 0;
  - counters 0;
  - `core_start`, `busy`, `error` all 0;
  - `core_decrypt` = 1;
  - synchronizer flops 1 (button released).
  - Reset mid-operation, including in `WAIT_CORE`, abandons the core transaction. A later `core_done` is ignored.
- **Button latency.** The physical falling edge of `send_data` produces `press` 3 cycles later. The register load is visible on the following edge.
- **Start latency.** `decr_go` sampled high in `READY` gives `core_start` high exactly 1 cycle later. `core_key` and `core_din` are stable from before `core_start` until `DONE`.
- **Result latency.** `msg` updates on the edge after `core_done`. `busy` falls on that same edge.
- **Display.** Segment outputs are combinational from registered state and data.

## Structure
- **Shared package `des_ui_pkg`:**
  - state encoding as 5-bit localparams, with `ERROR` = 5'b11111;
  - `CHUNKS` = 4;
  - the word-select decode.
- **Sub-modules:**
  - Reuse the existing `seven_segment` (4-bit in, 7-bit out), instantiated four times.
  - The synchronizer plus edge detector is one natural sub-module, `btn_edge`, so the encrypt side can share it.

## Test plan
- **Key entry.** Reset, then 4 presses with `user_input` = 0x0123, 0x4567, 0x89AB, 0xCDEF → `core_key` = 0x0123456789ABCDEF and state `IN_CT`. With `select_disp` = 3, `seg7_most` shows "0".
- **Held button.** Hold `send_data` low for 50 cycles → exactly one chunk captured, and the counter increments by 1 only.
- **Full decrypt.** Use key 0x133457799BBCDFF1 and ciphertext 0x85E813540F0AB405 with a model DES core whose `core_done` comes 16 cycles after start. Pulse `decr_go` → `core_start` 1 cycle later, then `msg` = 0x0123456789ABCDEF on the edge after `core_done`, state `DONE`.
- **Timeout.** The core never asserts `core_done` → `error` = 1 after `TIMEOUT` cycles in `WAIT_CORE`; `msg` stays 0.
- **Ignored inputs.**
  - `decr_go` pulsed during `IN_CT` → no `core_start`.
  - A stray `core_done` in `READY` → `msg` unchanged.
- **Reset mid-operation.** Assert `rst` in `WAIT_CORE`, then `core_done` 2 cycles after release → state `IN_KEY`, and `core_key`, `core_din` and `msg` all 0.
